// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern-detect stream controller.
package seq_det_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int PAT_W  = 4;
    localparam int HIST_W = PAT_W - 1;
    localparam int FILL_W = 2;

    localparam logic [FILL_W-1:0] FILL_FULL = 2'd3;

endpackage

// File: rtl/seq_det_stream_ctrl_core.sv
// Mealy 4-bit pattern detector: 3-bit history plus fill counter gating early matches.
// Optional macro SEQ_DET_NONOVERLAP_EN restarts the fill count after each match.
module pattern_det_core
    import seq_det_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    logic [HIST_W-1:0] hist_q;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;

    assign match = bit_en && (fill_q == FILL_FULL) && ({hist_q, bit_in} == pattern);

    // Fill count advance; saturates so a full history keeps matching on every bit
    always_comb begin
        fill_d = fill_q;
`ifdef SEQ_DET_NONOVERLAP_EN
        if (match) begin
            fill_d = '0;
        end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 2'd1;
        end else begin
            fill_d = fill_q;
        end
`else
        if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 2'd1;
        end else begin
            fill_d = fill_q;
        end
`endif
    end

    // History only moves on enabled bits and is kept across word boundaries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (bit_en) begin
            hist_q <= {hist_q[HIST_W-2:0], bit_in};
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-to-bit serializer feeding pattern_det_core, with detection counter and sticky irq.
// Optional macro SEQ_DET_NONOVERLAP_EN selects non-overlapping detection in the core.
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [CNT_W-1:0]  threshold,
    output logic              ser_bit,
    output logic              det_pulse,
    output logic [CNT_W-1:0]  det_count,
    output logic              irq,
    output logic              busy
);

    localparam int BCNT_W = $clog2(DATA_W);
    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic              det_pulse_q;
    logic [CNT_W-1:0]  det_count_q;
    logic [CNT_W-1:0]  det_count_d;
    logic              irq_q;
    logic              irq_set_s;
    logic              bit_en_s;
    logic              match_s;

    assign s_ready   = (state_q == IDLE) && en && !clr;
    assign busy      = (state_q == SHIFT);
    assign ser_bit   = shift_q[DATA_W-1];
    assign bit_en_s  = (state_q == SHIFT) && en;
    assign det_pulse = det_pulse_q;
    assign det_count = det_count_q;
    assign irq       = irq_q;

    pattern_det_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .bit_en  (bit_en_s),
        .bit_in  (ser_bit),
        .pattern (pattern),
        .match   (match_s)
    );

    // Saturating count update and threshold hit on the updated value
    always_comb begin
        det_count_d = det_count_q;
        if (match_s && (det_count_q != CNT_MAX)) begin
            det_count_d = det_count_q + CNT_W'(1);
        end else begin
            det_count_d = det_count_q;
        end
        irq_set_s = match_s && (threshold != '0) && (det_count_d == threshold);
    end

    // Control FSM, shifter, bit counter and registered detection outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcnt_q      <= '0;
            det_pulse_q <= 1'b0;
            det_count_q <= '0;
            irq_q       <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcnt_q      <= '0;
            det_pulse_q <= 1'b0;
            det_count_q <= '0;
            irq_q       <= 1'b0;
        end else if (!en) begin
            det_pulse_q <= 1'b0;
        end else begin
            det_pulse_q <= match_s;
            det_count_q <= det_count_d;
            if (irq_set_s) begin
                irq_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (s_valid) begin
                        shift_q <= s_data;
                        bcnt_q  <= LAST_IDX;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    bcnt_q  <= bcnt_q - BCNT_W'(1);
                    if (bcnt_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Directed scoreboard bench for seq_det_stream_ctrl (DATA_W=8, CNT_W=4).
module tb_seq_det_stream_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

`ifdef SEQ_DET_NONOVERLAP_EN
    localparam int AA_HITS   = 2;
    localparam int SAT_HITS  = 12;
    localparam int ZERO_HITS = 2;
`else
    localparam int AA_HITS   = 3;
    localparam int SAT_HITS  = 15;
    localparam int ZERO_HITS = 5;
`endif

    logic              clk = 1'b0;
    logic              rst_n, en, clr, s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [3:0]        pattern;
    logic [CNT_W-1:0]  threshold;
    logic              ser_bit, det_pulse, irq, busy;
    logic [CNT_W-1:0]  det_count;

    typedef struct packed {
        logic             pulse;
        logic             irq;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [3:0]       mdl_win;
    int               mdl_seen;
    logic [CNT_W-1:0] mdl_cnt;
    logic             mdl_irq;

    always #5 clk = ~clk;

    seq_det_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .pattern   (pattern),
        .threshold (threshold),
        .ser_bit   (ser_bit),
        .det_pulse (det_pulse),
        .det_count (det_count),
        .irq       (irq),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        mdl_win  = 4'd0;
        mdl_seen = 0;
        mdl_cnt  = '0;
        mdl_irq  = 1'b0;
        exp_q.delete();
    endtask

    // Reference detector: sliding 4-bit window, needs 4 bits since last clear
    task automatic mdl_feed(input logic b);
        exp_t e;
        logic hit;
        mdl_win = {mdl_win[2:0], b};
        if (mdl_seen < 4) mdl_seen++;
        hit = (mdl_seen == 4) && (mdl_win == pattern);
        if (hit) begin
            if (mdl_cnt != {CNT_W{1'b1}}) mdl_cnt = mdl_cnt + 1'b1;
            if ((threshold != 0) && (mdl_cnt == threshold)) mdl_irq = 1'b1;
`ifdef SEQ_DET_NONOVERLAP_EN
            mdl_seen = 0;
`endif
        end
        e.pulse = hit;
        e.irq   = mdl_irq;
        e.cnt   = mdl_cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        #1;
        check("clr_ready_low", s_ready, 1'b0);
        step();
        clr = 1'b0;
        mdl_clear();
        check("clr_count", det_count, 0);
        check("clr_irq", irq, 1'b0);
        check("clr_busy", busy, 1'b0);
    endtask

    // Send one word; optional 5-cycle stall before bit stall_pos, optional clr abort at abort_pos
    task automatic send_word(input logic [DATA_W-1:0] w, input int stall_pos, input int abort_pos);
        int   waited;
        exp_t e;
        logic b;
        waited = 0;
        while (!s_ready && waited < 20) begin
            step();
            waited++;
        end
        check("ready_wait", s_ready, 1'b1);
        s_valid = 1'b1;
        s_data  = w;
        step();
        s_valid = 1'b0;
        s_data  = '0;
        for (int k = 0; k < DATA_W; k++) begin
            b = w[DATA_W-1-k];
            if (k == stall_pos) begin
                en = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    check("stall_ser_bit", ser_bit, b);
                    check("stall_pulse", det_pulse, 1'b0);
                    check("stall_ready", s_ready, 1'b0);
                    check("stall_busy", busy, 1'b1);
                end
                en = 1'b1;
            end
            check("ser_bit", ser_bit, b);
            check("shift_ready", s_ready, 1'b0);
            check("shift_busy", busy, 1'b1);
            if (k == abort_pos) begin
                clr     = 1'b1;
                s_valid = 1'b1;
                s_data  = 8'hFF;
                #1;
                check("abort_ready", s_ready, 1'b0);
                step();
                clr     = 1'b0;
                s_valid = 1'b0;
                s_data  = '0;
                mdl_clear();
                check("abort_busy", busy, 1'b0);
                check("abort_pulse", det_pulse, 1'b0);
                check("abort_count", det_count, 0);
                check("abort_irq", irq, 1'b0);
                return;
            end
            mdl_feed(b);
            step();
            e = exp_q.pop_front();
            check("det_pulse", det_pulse, e.pulse);
            check("det_count", det_count, e.cnt);
            check("irq", irq, e.irq);
        end
        check("end_ready", s_ready, 1'b1);
        check("end_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0;
        pattern = 4'b1010; threshold = '0;
        mdl_clear();
        step();
        step();
        rst_n = 1'b1;
        check("rst_ready", s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ser_bit", ser_bit, 1'b0);
        check("rst_pulse", det_pulse, 1'b0);
        check("rst_count", det_count, 0);
        check("rst_irq", irq, 1'b0);

        // Basic overlapping detection within one word
        send_word(8'hAA, -1, -1);
        check("aa_count", det_count, AA_HITS);

        // Match spanning a word boundary, then the same with clr in between
        do_clr();
        send_word(8'h05, -1, -1);
        check("w1_count", det_count, 0);
        send_word(8'h00, -1, -1);
        check("cross_count", det_count, 1);
        do_clr();
        send_word(8'h05, -1, -1);
        do_clr();
        send_word(8'h00, -1, -1);
        check("cross_clr_count", det_count, 0);

        // Threshold irq, sticky across threshold change, cleared by clr
        threshold = 4'd3;
        send_word(8'hAA, -1, -1);
        send_word(8'hAA, -1, -1);
        check("irq_set", irq, 1'b1);
        threshold = 4'd9;
        send_word(8'hAA, -1, -1);
        check("irq_sticky", irq, 1'b1);
        do_clr();
        threshold = '0;

        // clr aborts on the would-be matching bit, then a clean word
        send_word(8'hAA, -1, 3);
        send_word(8'hAA, -1, -1);
        check("post_abort_count", det_count, AA_HITS);

        // Five-cycle stall mid-word
        do_clr();
        send_word(8'hAA, 4, -1);
        check("stall_count", det_count, AA_HITS);

        // Saturation of the 4-bit counter
        do_clr();
        for (int i = 0; i < 6; i++) send_word(8'hAA, -1, -1);
        check("sat_count", det_count, SAT_HITS);

        // All-zero pattern: fill gating blocks matches before 4 bits
        do_clr();
        pattern = 4'b0000;
        send_word(8'h00, -1, -1);
        check("zero_count", det_count, ZERO_HITS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
